// File: rtl/bee_pkg.sv
// Shared types and constants for the Bee-Scape game-flow controller.
// GAME_PAUSE_EN adds the PAUSE state to the state encoding.
package bee_pkg;

   localparam int unsigned KEY_W   = 8;
   localparam int unsigned SCORE_W = 16;
   localparam int unsigned LIVES_W = 3;
   localparam int unsigned TIMER_W = 8;
   localparam int unsigned STATE_W = 3;

   localparam logic [KEY_W-1:0]   KEY_SPACE = 8'h2C;
   localparam logic [KEY_W-1:0]   KEY_P     = 8'h13;
   localparam logic [SCORE_W-1:0] BCD_MAX   = 16'h9999;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 3'd0,
      PLAY = 3'd1,
      HIT  = 3'd2,
      OVER = 3'd3
`ifdef GAME_PAUSE_EN
      ,
      PAUSE = 3'd4
`endif
   } game_state_t;

endpackage

// File: rtl/bee_game_ctrl_bcd.sv
// bcd_counter4: 4-digit BCD incrementer with synchronous clear, enable,
// saturation at 9999, and a combinational greater-than against another BCD value.
module bcd_counter4
   import bee_pkg::*;
(
   input  logic               frame_clk,
   input  logic               Reset,
   input  logic               i_clr,
   input  logic               i_en,
   input  logic [SCORE_W-1:0] i_cmp,
   output logic [SCORE_W-1:0] o_q,
   output logic               o_gt_c
);

   logic [SCORE_W-1:0] r_q;

   function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
      logic [SCORE_W-1:0] r;
      logic               c;
      r = v;
      c = 1'b1;
      for (int d = 0; d < 4; d++) begin
         if (c) begin
            if (r[4*d +: 4] == 4'd9) begin
               r[4*d +: 4] = 4'd0;
            end else begin
               r[4*d +: 4] = r[4*d +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset)                       r_q <= '0;
      else if (i_clr)                  r_q <= '0;
      else if (i_en && r_q != BCD_MAX) r_q <= bcd_inc(r_q);
   end

   // Digit-wise compare, most significant digit decides first
   always_comb begin
      logic decided;
      o_gt_c  = 1'b0;
      decided = 1'b0;
      for (int d = 3; d >= 0; d--) begin
         if (!decided && r_q[4*d +: 4] != i_cmp[4*d +: 4]) begin
            o_gt_c  = r_q[4*d +: 4] > i_cmp[4*d +: 4];
            decided = 1'b1;
         end
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/bee_game_ctrl.sv
// Bee-Scape game-flow controller: title/play/hit/over sequencing, lives and BCD score.
// Optional pause state when GAME_PAUSE_EN is defined.
module bee_game_ctrl
   import bee_pkg::*;
#(
   parameter int unsigned       LIVES      = 3,
   parameter int unsigned       HIT_FRAMES = 60,
   parameter logic [KEY_W-1:0]  START_KEY  = KEY_SPACE
`ifdef GAME_PAUSE_EN
   ,
   parameter logic [KEY_W-1:0]  PAUSE_KEY  = KEY_P
`endif
)(
   input  logic               Reset,
   input  logic               frame_clk,
   input  logic [KEY_W-1:0]   keycode,
   input  logic               L,
   input  logic               obs_pass,
   output logic               play_en,
   output logic               respawn,
   output logic               flash,
   output logic               game_over,
   output logic [STATE_W-1:0] state,
   output logic [LIVES_W-1:0] lives,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score
);

   game_state_t        r_state, w_nx_state;
   logic [KEY_W-1:0]   r_key_prev;
   logic               r_l_prev;
   logic [LIVES_W-1:0] r_lives, w_nx_lives;
   logic [TIMER_W-1:0] r_timer, w_nx_timer;
   logic [SCORE_W-1:0] r_high, w_score;
   logic               r_play_en, r_respawn, r_flash, r_game_over;
   logic               w_nx_respawn, w_clr, w_en, w_hs_load, w_gt_c;
   logic               w_start_press, w_hit;

   assign w_start_press = (keycode == START_KEY) && (r_key_prev != START_KEY);
   assign w_hit         = L && !r_l_prev;
`ifdef GAME_PAUSE_EN
   logic w_pause_press;
   assign w_pause_press = (keycode == PAUSE_KEY) && (r_key_prev != PAUSE_KEY);
`endif

   bcd_counter4 u_score (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .i_clr     (w_clr),
      .i_en      (w_en),
      .i_cmp     (r_high),
      .o_q       (w_score),
      .o_gt_c    (w_gt_c)
   );

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_key_prev  <= '0;
         r_l_prev    <= 1'b0;
         r_lives     <= LIVES_W'(LIVES);
         r_timer     <= '0;
         r_high      <= '0;
         r_play_en   <= 1'b0;
         r_respawn   <= 1'b0;
         r_flash     <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_state     <= w_nx_state;
         r_key_prev  <= keycode;
         r_l_prev    <= L;
         r_lives     <= w_nx_lives;
         r_timer     <= w_nx_timer;
         if (w_hs_load) r_high <= w_score;
         r_play_en   <= (w_nx_state == PLAY);
         r_respawn   <= w_nx_respawn;
         r_flash     <= (w_nx_state == HIT) && w_nx_timer[2];
         r_game_over <= (w_nx_state == OVER);
      end
   end

   // Next-state, lives, hit timer and score control
   always_comb begin
      w_nx_state   = r_state;
      w_nx_lives   = r_lives;
      w_nx_timer   = r_timer;
      w_nx_respawn = 1'b0;
      w_clr        = 1'b0;
      w_en         = 1'b0;
      w_hs_load    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start_press) begin
               w_nx_state   = PLAY;
               w_nx_lives   = LIVES_W'(LIVES);
               w_clr        = 1'b1;
               w_nx_respawn = 1'b1;
            end
         end
         PLAY: begin
            if (w_hit) begin
               if (r_lives > LIVES_W'(1)) begin
                  w_nx_lives = r_lives - LIVES_W'(1);
                  w_nx_timer = TIMER_W'(HIT_FRAMES);
                  w_nx_state = HIT;
               end else begin
                  w_nx_lives = '0;
                  w_nx_state = OVER;
                  w_hs_load  = w_gt_c;
               end
            end else begin
               w_en = obs_pass;
`ifdef GAME_PAUSE_EN
               if (w_pause_press) w_nx_state = PAUSE;
`endif
            end
         end
         HIT: begin
            if (r_timer <= TIMER_W'(1)) begin
               w_nx_timer   = '0;
               w_nx_state   = PLAY;
               w_nx_respawn = 1'b1;
            end else begin
               w_nx_timer = r_timer - TIMER_W'(1);
            end
         end
         OVER: begin
            if (w_start_press) w_nx_state = IDLE;
         end
`ifdef GAME_PAUSE_EN
         PAUSE: begin
            if (w_pause_press) w_nx_state = PLAY;
         end
`endif
         default: w_nx_state = IDLE;
      endcase
   end

   assign play_en    = r_play_en;
   assign respawn    = r_respawn;
   assign flash      = r_flash;
   assign game_over  = r_game_over;
   assign state      = r_state;
   assign lives      = r_lives;
   assign score      = w_score;
   assign high_score = r_high;

endmodule

// File: tb/tb_bee_game_ctrl.sv
// Directed testbench for bee_game_ctrl; pause checks follow GAME_PAUSE_EN.
module tb_bee_game_ctrl;

   logic        Reset;
   logic        frame_clk;
   logic [7:0]  keycode;
   logic        L;
   logic        obs_pass;
   logic        play_en, respawn, flash, game_over;
   logic [2:0]  state;
   logic [2:0]  lives;
   logic [15:0] score, high_score;

   int n_vec = 0;
   int n_err = 0;

   bee_game_ctrl dut (
      .Reset      (Reset),
      .frame_clk  (frame_clk),
      .keycode    (keycode),
      .L          (L),
      .obs_pass   (obs_pass),
      .play_en    (play_en),
      .respawn    (respawn),
      .flash      (flash),
      .game_over  (game_over),
      .state      (state),
      .lives      (lives),
      .score      (score),
      .high_score (high_score)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1; keycode = 8'h00; L = 1'b0; obs_pass = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
      tick();
   endtask

   // Press and release start; ends in PLAY
   task automatic press_start();
      keycode = 8'h2C; tick();
      keycode = 8'h00; tick();
   endtask

   task automatic hit_and_recover();
      L = 1'b1; tick();
      L = 1'b0;
      repeat (60) tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
      n_vec++; if (lives !== 3'd3) begin n_err++; $display("FAIL reset_lives got %0d want 3", lives); end
      n_vec++; if ({play_en, respawn, flash, game_over} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", {play_en, respawn, flash, game_over}); end
      n_vec++; if ({score, high_score} !== 32'h0) begin n_err++; $display("FAIL reset_scores got %h want 0", {score, high_score}); end
   endtask

   task automatic test_start();
      keycode = 8'h2C; tick();
      n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL start_state got %0d want 1", state); end
      n_vec++; if (respawn !== 1'b1) begin n_err++; $display("FAIL start_respawn got %b want 1", respawn); end
      n_vec++; if (lives !== 3'd3 || score !== 16'h0 || play_en !== 1'b1) begin n_err++; $display("FAIL start_vals got lives=%0d score=%h play_en=%b want 3 0000 1", lives, score, play_en); end
      tick();
      n_vec++; if (respawn !== 1'b0 || state !== 3'd1) begin n_err++; $display("FAIL start_hold got respawn=%b state=%0d want 0 1", respawn, state); end
      keycode = 8'h00;
   endtask

   task automatic test_score();
      for (int i = 0; i < 12; i++) begin
         obs_pass = 1'b1; tick();
         obs_pass = 1'b0; tick();
      end
      n_vec++; if (score !== 16'h0012) begin n_err++; $display("FAIL score_12 got %h want 0012", score); end
   endtask

   task automatic test_hit();
      logic [7:0] t;
      L = 1'b1; tick();
      n_vec++; if (state !== 3'd2 || lives !== 3'd2 || play_en !== 1'b0) begin n_err++; $display("FAIL hit_entry got state=%0d lives=%0d play_en=%b want 2 2 0", state, lives, play_en); end
      n_vec++; if (flash !== 1'b1) begin n_err++; $display("FAIL hit_flash0 got %b want 1", flash); end
      for (int k = 1; k < 60; k++) begin
         tick();
         t = 8'(60 - k);
         n_vec++; if (state !== 3'd2 || play_en !== 1'b0 || flash !== t[2]) begin n_err++; $display("FAIL hit_frame%0d got state=%0d play_en=%b flash=%b want 2 0 %b", k, state, play_en, flash, t[2]); end
      end
      tick();
      n_vec++; if (state !== 3'd1 || respawn !== 1'b1 || flash !== 1'b0 || play_en !== 1'b1) begin n_err++; $display("FAIL hit_exit got state=%0d respawn=%b flash=%b play_en=%b want 1 1 0 1", state, respawn, flash, play_en); end
      tick();
      n_vec++; if (state !== 3'd1 || lives !== 3'd2 || respawn !== 1'b0) begin n_err++; $display("FAIL hit_held_L got state=%0d lives=%0d respawn=%b want 1 2 0", state, lives, respawn); end
      L = 1'b0; tick();
   endtask

   task automatic test_game_over();
      do_reset();
      press_start();
      obs_pass = 1'b1; repeat (7) tick(); obs_pass = 1'b0;
      hit_and_recover();
      hit_and_recover();
      n_vec++; if (lives !== 3'd1 || state !== 3'd1 || score !== 16'h0007) begin n_err++; $display("FAIL pre_over got lives=%0d state=%0d score=%h want 1 1 0007", lives, state, score); end
      L = 1'b1; tick(); L = 1'b0;
      n_vec++; if (state !== 3'd3 || game_over !== 1'b1 || lives !== 3'd0 || play_en !== 1'b0) begin n_err++; $display("FAIL over_entry got state=%0d go=%b lives=%0d play_en=%b want 3 1 0 0", state, game_over, lives, play_en); end
      n_vec++; if (high_score !== 16'h0007) begin n_err++; $display("FAIL over_high got %h want 0007", high_score); end
      keycode = 8'h2C; tick(); keycode = 8'h00;
      n_vec++; if (state !== 3'd0 || game_over !== 1'b0 || high_score !== 16'h0007 || score !== 16'h0007) begin n_err++; $display("FAIL over_ack got state=%0d go=%b high=%h score=%h want 0 0 0007 0007", state, game_over, high_score, score); end
      tick();
   endtask

   task automatic test_hit_and_pass();
      press_start();
      n_vec++; if (score !== 16'h0 || lives !== 3'd3) begin n_err++; $display("FAIL restart got score=%h lives=%0d want 0000 3", score, lives); end
      obs_pass = 1'b1; repeat (4) tick(); obs_pass = 1'b0;
      L = 1'b1; obs_pass = 1'b1; tick();
      L = 1'b0; obs_pass = 1'b0;
      n_vec++; if (score !== 16'h0004 || lives !== 3'd2 || state !== 3'd2) begin n_err++; $display("FAIL hit_wins got score=%h lives=%0d state=%0d want 0004 2 2", score, lives, state); end
      repeat (10) tick();
      #3 Reset = 1'b1; #1;
      n_vec++; if (state !== 3'd0 || lives !== 3'd3 || high_score !== 16'h0 || flash !== 1'b0) begin n_err++; $display("FAIL mid_hit_reset got state=%0d lives=%0d high=%h flash=%b want 0 3 0000 0", state, lives, high_score, flash); end
      tick();
      Reset = 1'b0; tick();
   endtask

   task automatic test_pause();
      do_reset();
      press_start();
      keycode = 8'h13; tick(); keycode = 8'h00;
`ifdef GAME_PAUSE_EN
      n_vec++; if (state !== 3'd4 || play_en !== 1'b0) begin n_err++; $display("FAIL pause_enter got state=%0d play_en=%b want 4 0", state, play_en); end
      L = 1'b1; obs_pass = 1'b1; tick(); L = 1'b0; obs_pass = 1'b0; tick();
      n_vec++; if (state !== 3'd4 || lives !== 3'd3 || score !== 16'h0) begin n_err++; $display("FAIL pause_frozen got state=%0d lives=%0d score=%h want 4 3 0000", state, lives, score); end
      keycode = 8'h13; tick(); keycode = 8'h00;
      n_vec++; if (state !== 3'd1 || play_en !== 1'b1) begin n_err++; $display("FAIL pause_exit got state=%0d play_en=%b want 1 1", state, play_en); end
`else
      n_vec++; if (state !== 3'd1 || play_en !== 1'b1) begin n_err++; $display("FAIL pause_key_noop got state=%0d play_en=%b want 1 1", state, play_en); end
`endif
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      press_start();
      obs_pass = 1'b1;
      repeat (9998) tick();
      n_vec++; if (score !== 16'h9998) begin n_err++; $display("FAIL score_9998 got %h want 9998", score); end
      tick();
      n_vec++; if (score !== 16'h9999) begin n_err++; $display("FAIL score_9999 got %h want 9999", score); end
      tick();
      n_vec++; if (score !== 16'h9999) begin n_err++; $display("FAIL score_sat got %h want 9999", score); end
      obs_pass = 1'b0;
   endtask

   initial begin
      test_reset();
      test_start();
      test_score();
      test_hit();
      test_game_over();
      test_hit_and_pass();
      test_pause();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
